// File: rtl/ccff_loader_pkg.sv
// Shared FSM state type and counter-width helper for the configuration-chain loader.
// No logic of its own; imported by the loader and its word shifter.
package ccff_loader_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    // Width able to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Holds one bitstream word and presents it LSB first, one bit per shift, flagging the last bit.
// Load/shift take effect on the next edge; it never stalls, the caller decides when to shift.
module ccff_word_shifter #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              bit_o,
    output logic              last_o
);

    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IW-1:0]     idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = '0;
        end else if (shift_i && !last_o) begin
            word_d = word_q >> 1;
            idx_d  = idx_q + 1'b1;
        end
    end

    assign bit_o  = word_q[0];
    assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/ccff_loader.sv
// Streams CHAIN_LEN bitstream bits into a configuration flip-flop chain, one strobe per bit.
// One handshake cycle per word, SETTLE_CYCLES after the last bit; bs_ready only in FETCH.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN     = 1024,
    parameter int WORD_W        = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BW = cnt_w(CHAIN_LEN);
    localparam int TW = cnt_w(TIMEOUT);
    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STL_LAST  = SW'(SETTLE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   stl_cnt_q, stl_cnt_d;
    logic            xfer, sh_bit, sh_last;

    assign xfer = bs_valid & bs_ready;

    ccff_word_shifter #(.WORD_W(WORD_W)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (xfer),
        .shift_i (prog_clk_en),
        .word_i  (bs_data),
        .bit_o   (sh_bit),
        .last_o  (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            stl_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stl_cnt_q <= stl_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        stl_cnt_d = stl_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    stl_cnt_d = '0;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_ERROR;
                end else if (bs_valid) begin
                    state_d  = ST_SHIFT;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_LAST) state_d = ST_ERROR;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_ERROR;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Chain completion wins over word end: spare bits of the last word are dropped.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_SETTLE;
                        stl_cnt_d = '0;
                    end else if (sh_last) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_ERROR;
                end else begin
                    stl_cnt_d = stl_cnt_q + 1'b1;
                    if (stl_cnt_q == STL_LAST) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Abort gates the handshake and the strobe combinationally so neither can slip through.
    always_comb begin
        bs_ready    = 1'b0;
        prog_clk_en = 1'b0;
        ccff_head   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                busy     = 1'b1;
                bs_ready = ~abort;
            end
            ST_SHIFT: begin
                busy        = 1'b1;
                prog_clk_en = ~abort;
                ccff_head   = sh_bit & ~abort;
            end
            ST_SETTLE: busy  = 1'b1;
            ST_DONE:   done  = 1'b1;
            ST_ERROR:  error = 1'b1;
            default:   busy  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed and randomized loads of a 10-bit chain, checked against a word-list bit model.
module tb_ccff_loader;

    localparam int CL = 10;
    localparam int WW = 8;
    localparam int SC = 4;
    localparam int TO = 5;
    localparam int NW = (CL + WW - 1) / WW;
    localparam int BUDGET = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic bs_valid = 1'b0;
    logic [WW-1:0] bs_data = '0;
    logic bs_ready, ccff_head, prog_clk_en, busy, done, error;

    int total = 0;
    int bad = 0;
    bit cap[$];
    logic [WW-1:0] words [NW];
    int r_done, r_err, r_last, r_abort, r_idx, r_waits;

    always #5 clk = ~clk;

    ccff_loader #(
        .CHAIN_LEN(CL), .WORD_W(WW), .SETTLE_CYCLES(SC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .prog_clk_en(prog_clk_en),
        .busy(busy), .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (prog_clk_en) cap.push_back(ccff_head);
        else chk("head_without_strobe", {31'd0, ccff_head}, 32'd0);
        chk("ready_while_not_busy", {31'd0, bs_ready & ~busy}, 32'd0);
    end

    function automatic logic [CL-1:0] exp_bits();
        logic [CL-1:0] e;
        e = '0;
        for (int i = 0; i < CL; i++) e[i] = words[i / WW][i % WW];
        return e;
    endfunction

    function automatic logic [CL-1:0] got_bits();
        logic [CL-1:0] g;
        g = '0;
        for (int i = 0; i < CL && i < cap.size(); i++) g[i] = cap[i];
        return g;
    endfunction

    task automatic run_load(input int gap, input int abort_at, input bit start_mid,
                            input bit start_abort, input int reset_at);
        int waits;
        int need;
        bit ended;
        waits = 0;
        ended = 1'b0;
        r_done = -1; r_err = -1; r_last = -1; r_abort = -1; r_idx = 0; r_waits = 0;
        @(posedge clk); #1;
        cap.delete();
        start = 1'b1;
        abort = start_abort;
        need = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            start = 1'b0;
            abort = 1'b0;
            bs_valid = 1'b0;
            if (reset_at >= 0 && prog_clk_en && cap.size() == reset_at) begin
                rst_n = 1'b0;
                ended = 1'b1;
                break;
            end
            if (abort_at >= 0 && prog_clk_en && cap.size() == abort_at - 1) begin
                abort = 1'b1;
                r_abort = cyc;
            end
            if (start_mid && prog_clk_en && cap.size() == 5) start = 1'b1;
            if (bs_ready && !abort) begin
                if (waits < need) begin
                    waits++;
                    r_waits++;
                end else begin
                    bs_valid = 1'b1;
                    bs_data = (r_idx < NW) ? words[r_idx] : '0;
                    r_idx++;
                    waits = 0;
                    need = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                end
            end
            @(negedge clk);
            if (cyc == 0) chk("start_clears_status", {29'd0, busy, done, error}, 32'b100);
            if (prog_clk_en) r_last = cyc;
            if (done && r_done < 0) r_done = cyc;
            if (error && r_err < 0) r_err = cyc;
            if (done || error) begin
                ended = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("load_terminated", {31'd0, ended}, 32'd1);
        if (reset_at < 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            bs_valid = 1'b0;
        end
    endtask

    task automatic check_ok();
        chk("strobe_count", cap.size(), CL);
        chk("bit_sequence", got_bits(), exp_bits());
        chk("done_after_settle", r_done - r_last, SC + 1);
        chk("done_level", {31'd0, done}, 32'd1);
        chk("words_fetched", r_idx, NW);
    endtask

    initial begin
        logic [CL-1:0] ref_seq;
        ref_seq = 10'b1110100101;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, bs_ready, ccff_head, prog_clk_en, busy, done, error}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        words[0] = 8'hA5;
        words[1] = 8'h03;
        run_load(0, -1, 1'b0, 1'b0, -1);
        check_ok();
        chk("a5_03_literal", got_bits(), ref_seq);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ignored_done", {30'd0, done, error}, 32'b10);

        @(posedge clk); #1;
        run_load(3, -1, 1'b0, 1'b0, -1);
        check_ok();
        chk("ready_wait_cycles", r_waits, 3 * NW);
        chk("stall_bits_literal", got_bits(), ref_seq);

        run_load(1000, -1, 1'b0, 1'b0, -1);
        chk("timeout_cycle", r_err, TO);
        chk("timeout_strobes", cap.size(), 0);
        chk("timeout_status", {30'd0, done, error}, 32'b01);

        run_load(0, 4, 1'b0, 1'b0, -1);
        chk("abort_strobes", cap.size(), 3);
        chk("abort_latency", r_err - r_abort, 1);
        chk("abort_ready_low", {31'd0, bs_ready}, 32'd0);
        chk("abort_error", {31'd0, error}, 32'd1);

        run_load(0, -1, 1'b0, 1'b0, 4);
        @(negedge clk);
        chk("reset_mid_outputs", {26'd0, bs_ready, ccff_head, prog_clk_en, busy, done, error}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_no_strobes", cap.size(), 4);
        rst_n = 1'b1;
        run_load(0, -1, 1'b0, 1'b1, -1);
        check_ok();

        run_load(0, -1, 1'b1, 1'b0, -1);
        check_ok();
        run_load(0, -1, 1'b0, 1'b0, -1);
        check_ok();

        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
            run_load(-1, -1, 1'b0, 1'b0, -1);
            check_ok();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
